// File: rtl/regfile_dump_unit.sv
// Purpose : walks the register file through read port 1 and streams every register out as an idx/data beat.
// Latency : two cycles per beat (one READ cycle, then at least one SEND cycle); done pulses the cycle after the final handshake.
// Backpr. : a beat is held stable with dump_valid=1 until dump_ready; the walk does not advance while the consumer stalls.
//
// Ports   : CLK, nRST (synchronous, active-low); start / busy / done control;
//           rsel1/rdat1 read port driven with the walk index, rsel2 tied to 0, rdat2 unused;
//           dump_valid/dump_ready handshake carrying dump_idx, dump_data and dump_last.
// Option  : define REGDUMP_CHECKSUM_EN to append one checksum beat (XOR of all register beats, idx 0) after idx 31.
module regfile_dump_unit #(
   parameter int SKIP_ZERO = 0
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [4:0]  rsel1,
   output logic [4:0]  rsel2,
   input  logic [31:0] rdat1,
   input  logic [31:0] rdat2,
   output logic        dump_valid,
   input  logic        dump_ready,
   output logic [4:0]  dump_idx,
   output logic [31:0] dump_data,
   output logic        dump_last
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      SEND = 3'd2,
`ifdef REGDUMP_CHECKSUM_EN
      CHK  = 3'd3,
`endif
      DONE = 3'd4
   } state_t;

   localparam logic [4:0] FIRST_IDX = (SKIP_ZERO != 0) ? 5'd1 : 5'd0;
   localparam logic [4:0] LAST_IDX  = 5'd31;

   state_t      state;
   logic [4:0]  idx;
`ifdef REGDUMP_CHECKSUM_EN
   logic [31:0] acc;
`endif

   // rdat2 is part of the register-file port bundle but carries nothing we need.
   logic unused_rdat2;
   assign unused_rdat2 = ^rdat2;

   assign rsel1 = idx;
   assign rsel2 = 5'd0;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state      <= IDLE;
         idx        <= 5'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         dump_valid <= 1'b0;
         dump_last  <= 1'b0;
         dump_idx   <= 5'd0;
         dump_data  <= 32'd0;
`ifdef REGDUMP_CHECKSUM_EN
         acc        <= 32'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= READ;
                  idx   <= FIRST_IDX;
                  busy  <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                  acc   <= 32'd0;
`endif
               end
            end

            // rsel1 already carries idx, so rdat1 is the register being captured.
            READ: begin
               dump_data  <= rdat1;
               dump_idx   <= idx;
               dump_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
               dump_last  <= 1'b0;
`else
               dump_last  <= (idx == LAST_IDX);
`endif
               state      <= SEND;
            end

            SEND: begin
               if (dump_ready) begin
                  dump_valid <= 1'b0;
                  dump_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                  acc        <= acc ^ dump_data;
`endif
                  if (idx == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
                     // Checksum beat is presented straight away; it needs no read cycle.
                     state      <= CHK;
                     dump_valid <= 1'b1;
                     dump_idx   <= 5'd0;
                     dump_data  <= acc ^ dump_data;
                     dump_last  <= 1'b1;
`else
                     state      <= DONE;
                     done       <= 1'b1;
`endif
                  end else begin
                     // idx only advances below 31, so it can never wrap.
                     idx   <= idx + 5'd1;
                     state <= READ;
                  end
               end
            end

`ifdef REGDUMP_CHECKSUM_EN
            CHK: begin
               if (dump_ready) begin
                  dump_valid <= 1'b0;
                  dump_last  <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
               end
            end
`endif

            // busy stays high here and drops as IDLE is re-entered.
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Bench for regfile_dump_unit: two instances (SKIP_ZERO=0 and SKIP_ZERO=1) sharing a register file,
// an expected-beat list model per instance checked every cycle, plus directed literal expectations.
module tb_regfile_dump_unit;

`ifdef REGDUMP_CHECKSUM_EN
   localparam bit CKSUM  = 1'b1;
   localparam int NBEATS = 33;
`else
   localparam bit CKSUM  = 1'b0;
   localparam int NBEATS = 32;
`endif

   logic        CLK = 1'b0;
   logic        nRST;
   logic [1:0]  st;
   logic [1:0]  rdy;
   logic [1:0]  busy_o, done_o, vld_o, last_o;
   logic [4:0]  idx_o [2];
   logic [4:0]  rs1 [2];
   logic [4:0]  rs2 [2];
   logic [31:0] dat_o [2];
   logic [31:0] rd1 [2];
   logic [31:0] rf [32];

   always #5 CLK = ~CLK;

   assign rd1[0] = rf[rs1[0]];
   assign rd1[1] = rf[rs1[1]];

   regfile_dump_unit #(.SKIP_ZERO(0)) dut0 (
      .CLK(CLK), .nRST(nRST), .start(st[0]), .busy(busy_o[0]), .done(done_o[0]),
      .rsel1(rs1[0]), .rsel2(rs2[0]), .rdat1(rd1[0]), .rdat2(32'hDEADBEEF),
      .dump_valid(vld_o[0]), .dump_ready(rdy[0]), .dump_idx(idx_o[0]),
      .dump_data(dat_o[0]), .dump_last(last_o[0]));

   regfile_dump_unit #(.SKIP_ZERO(1)) dut1 (
      .CLK(CLK), .nRST(nRST), .start(st[1]), .busy(busy_o[1]), .done(done_o[1]),
      .rsel1(rs1[1]), .rsel2(rs2[1]), .rdat1(rd1[1]), .rdat2(32'h12345678),
      .dump_valid(vld_o[1]), .dump_ready(rdy[1]), .dump_idx(idx_o[1]),
      .dump_data(dat_o[1]), .dump_last(last_o[1]));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- model: list of beats still owed to the consumer ----------------
   logic [4:0]  q_idx  [2][40];
   logic [31:0] q_dat  [2][40];
   bit          q_last [2][40];
   bit          q_rd   [2][40];   // beat is preceded by a register read cycle
   int          hd [2];
   int          tl [2];
   bit          m_busy [2];
   bit          m_done [2];
   bit          m_show [2];
   bit          armed = 1'b0;

   task automatic fill(input int u);
      logic [31:0] x;
      x = 32'd0;
      hd[u] = 0;
      tl[u] = 0;
      for (int i = (u == 1) ? 1 : 0; i < 32; i++) begin
         q_idx[u][tl[u]]  = 5'(i);
         q_dat[u][tl[u]]  = rf[i];
         q_last[u][tl[u]] = (i == 31) && !CKSUM;
         q_rd[u][tl[u]]   = 1'b1;
         x = x ^ rf[i];
         tl[u]++;
      end
`ifdef REGDUMP_CHECKSUM_EN
      q_idx[u][tl[u]]  = 5'd0;
      q_dat[u][tl[u]]  = x;
      q_last[u][tl[u]] = 1'b1;
      q_rd[u][tl[u]]   = 1'b0;
      tl[u]++;
`endif
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         m_busy[u] = 0; m_done[u] = 0; m_show[u] = 0; hd[u] = 0; tl[u] = 0;
      end
      forever begin
         @(posedge CLK);
         if (nRST === 1'b0) armed = 1'b1;
         for (int u = 0; u < 2; u++) begin
            if (nRST !== 1'b1) begin
               m_busy[u] = 0; m_done[u] = 0; m_show[u] = 0; hd[u] = 0; tl[u] = 0;
            end else if (m_done[u]) begin
               m_done[u] = 0;
               m_busy[u] = 0;
            end else if (!m_busy[u]) begin
               if (st[u]) begin
                  m_busy[u] = 1;
                  m_show[u] = 0;
                  fill(u);
               end
            end else if (m_show[u]) begin
               if (rdy[u]) begin
                  hd[u]++;
                  m_show[u] = 0;
                  if (hd[u] == tl[u]) m_done[u] = 1;
                  else if (!q_rd[u][hd[u]]) m_show[u] = 1;
               end
            end else begin
               m_show[u] = 1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge CLK);
         if (armed) begin
            for (int u = 0; u < 2; u++) begin
               chk($sformatf("u%0d busy", u),  32'(busy_o[u]), 32'(m_busy[u]));
               chk($sformatf("u%0d done", u),  32'(done_o[u]), 32'(m_done[u]));
               chk($sformatf("u%0d valid", u), 32'(vld_o[u]),  32'(m_show[u]));
               chk($sformatf("u%0d rsel2", u), 32'(rs2[u]),    32'd0);
               if (m_show[u]) begin
                  chk($sformatf("u%0d idx", u),  32'(idx_o[u]),  32'(q_idx[u][hd[u]]));
                  chk($sformatf("u%0d data", u), dat_o[u],       q_dat[u][hd[u]]);
                  chk($sformatf("u%0d last", u), 32'(last_o[u]), 32'(q_last[u][hd[u]]));
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic pulse_start(input int u);
      @(posedge CLK); #1 st[u] = 1'b1;
      @(posedge CLK); #1 st[u] = 1'b0;
   endtask

   task automatic wait_valid(input int u, input int max, output int n);
      n = 0;
      while (n < max) begin
         @(negedge CLK);
         n++;
         if (vld_o[u] === 1'b1) break;
      end
   endtask

   task automatic run_to_done(input int u, input int max, output int n, output bit seen);
      n = 0;
      seen = 0;
      while (n < max && !seen) begin
         @(negedge CLK);
         n++;
         if (done_o[u] === 1'b1) seen = 1;
      end
   endtask

   task automatic wait_beat(input int u, input logic [4:0] want, output bit seen);
      seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge CLK);
         if (vld_o[u] === 1'b1 && idx_o[u] == want) seen = 1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n, nv, k;
      bit  seen;
      for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h11;
      nRST = 1'b0;
      st   = 2'b00;
      rdy  = 2'b11;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset busy",  32'(busy_o[0]), 32'd0);
      chk("reset valid", 32'(vld_o[0]),  32'd0);
      chk("reset last",  32'(last_o[0]), 32'd0);
      chk("reset idx",   32'(idx_o[0]),  32'd0);
      chk("reset data",  dat_o[0],       32'd0);
      @(negedge CLK) nRST = 1'b1;

      // full dump, ready held high
      pulse_start(0);
      wait_valid(0, 10, nv);
      chk("t1 first idx",  32'(idx_o[0]), 32'd0);
      chk("t1 first data", dat_o[0],      32'd0);
      run_to_done(0, 200, n, seen);
      chk("t1 done latency", 32'(nv + n), CKSUM ? 32'd66 : 32'd65);

      // SKIP_ZERO instance
      pulse_start(1);
      wait_valid(1, 10, nv);
      chk("t2 first idx",  32'(idx_o[1]), 32'd1);
      chk("t2 first data", dat_o[1],      32'h11);
      run_to_done(1, 200, n, seen);
      chk("t2 done latency", 32'(nv + n), CKSUM ? 32'd64 : 32'd63);

      // stall on the idx=7 beat
      pulse_start(0);
      wait_beat(0, 5'd7, seen);
      chk("t3 reached idx7", 32'(seen), 32'd1);
      rdy[0] = 1'b0;
      repeat (5) begin
         @(negedge CLK);
         chk("t3 stall valid", 32'(vld_o[0]), 32'd1);
         chk("t3 stall data",  dat_o[0],      32'h77);
         chk("t3 stall idx",   32'(idx_o[0]), 32'd7);
      end
      rdy[0] = 1'b1;
      run_to_done(0, 200, n, seen);
      chk("t3 done seen", 32'(seen), 32'd1);

      // reset mid-dump at idx 12
      pulse_start(0);
      wait_beat(0, 5'd12, seen);
      chk("t4 reached idx12", 32'(seen), 32'd1);
      nRST = 1'b0;
      @(posedge CLK); #1;
      chk("t4 rst busy",  32'(busy_o[0]), 32'd0);
      chk("t4 rst valid", 32'(vld_o[0]),  32'd0);
      chk("t4 rst done",  32'(done_o[0]), 32'd0);
      @(negedge CLK) nRST = 1'b1;
      repeat (4) begin
         @(negedge CLK);
         chk("t4 no done", 32'(done_o[0]), 32'd0);
      end
      pulse_start(0);
      wait_valid(0, 10, nv);
      chk("t4 restart idx", 32'(idx_o[0]), 32'd0);
      run_to_done(0, 200, n, seen);
      chk("t4 restart done", 32'(seen), 32'd1);

      // register file r[i]=i: checksum beat and last flags
      for (int i = 0; i < 32; i++) rf[i] = 32'(i);
      pulse_start(0);
      k = 0;
      seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge CLK);
         if (vld_o[0] === 1'b1) begin
            if (k == 31) begin
               chk("t5 idx31 idx",  32'(idx_o[0]),  32'd31);
               chk("t5 idx31 last", 32'(last_o[0]), 32'(!CKSUM));
            end
`ifdef REGDUMP_CHECKSUM_EN
            if (k == 32) begin
               chk("t5 cksum data", dat_o[0],       32'h0000_0000);
               chk("t5 cksum idx",  32'(idx_o[0]),  32'd0);
               chk("t5 cksum last", 32'(last_o[0]), 32'd1);
            end
`endif
            k++;
         end
         if (done_o[0] === 1'b1) seen = 1;
      end
      chk("t5 beat count", 32'(k), 32'(NBEATS));
      for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h11;

      // start while busy is ignored; start held across DONE relaunches once
      pulse_start(0);
      repeat (10) @(negedge CLK);
      pulse_start(0);
      repeat (10) @(negedge CLK);
      st[0] = 1'b1;
      run_to_done(0, 200, n, seen);
      chk("t6 done seen", 32'(seen), 32'd1);
      @(posedge CLK); #1;
      chk("t6 idle busy", 32'(busy_o[0]), 32'd0);
      @(posedge CLK); #1;
      chk("t6 relaunch busy", 32'(busy_o[0]), 32'd1);
      st[0] = 1'b0;
      run_to_done(0, 200, n, seen);
      chk("t6 relaunch done", 32'(seen), 32'd1);
      repeat (4) begin
         @(negedge CLK);
         chk("t6 stays idle", 32'(busy_o[0]), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_dump_unit.md
REGFILE_DUMP_UNIT -- requirements
Module: regfile_dump_unit

Interface
REQ-001 Parameter: SKIP_ZERO, default 0; when 1, register 0 is not emitted and the walk starts at index 1.
REQ-002 Port: CLK  in  1  rising-edge clock; all state updates on the rising edge.
REQ-003 Port: nRST  in  1  reset, synchronous and active-low.
REQ-004 Port: start  in  1  dump request, sampled in IDLE only.
REQ-005 Port: busy  out  1  high in every state except IDLE.
REQ-006 Port: done  out  1  one-cycle completion pulse.
REQ-007 Port: rsel1  out  5  register file read select 1.
REQ-008 Port: rsel2  out  5  register file read select 2; tied to 0.
REQ-009 Port: rdat1  in  32  combinational read data for rsel1.
REQ-010 Port: rdat2  in  32  unused.
REQ-011 Port: dump_valid  out  1  output beat valid.
REQ-012 Port: dump_ready  in  1  consumer accepts the beat.
REQ-013 Port: dump_idx  out  5  register index of the current beat.
REQ-014 Port: dump_data  out  32  register contents, or the checksum.
REQ-015 Port: dump_last  out  1  marks the final beat of a dump.

Function
REQ-016 The FSM SHALL have the states IDLE, READ, SEND, CHK and DONE.
REQ-017 IDLE -> READ SHALL occur when start=1, with idx loaded to 1 if SKIP_ZERO=1, else 0.
REQ-018 In READ, the block SHALL drive rsel1=idx, register rdat1 into dump_data and idx into dump_idx, then enter SEND; READ lasts 1 cycle.
REQ-019 In SEND, dump_valid SHALL be 1, and dump_data, dump_idx and dump_last SHALL stay stable until the cycle in which dump_ready=1.
REQ-020 On a SEND handshake with idx<31, the block SHALL increment idx and return to READ.
REQ-021 On a SEND handshake with idx=31, the block SHALL go to CHK if the macro is defined, else to DONE.
REQ-022 Consumer-visible latency SHALL be 2 cycles per beat when dump_ready is held high (READ then SEND).
REQ-023 In DONE, done=1 for exactly 1 cycle, then the FSM SHALL return to IDLE; busy SHALL be 1 in DONE.
REQ-024 start SHALL be ignored outside IDLE; start held high through DONE SHALL launch a new dump in the cycle after return to IDLE.
REQ-025 idx SHALL never wrap past 31; the 5-bit increment at idx=31 is never taken.
REQ-026 rsel1 SHALL equal idx in all states; rsel2 SHALL always equal 0.
REQ-027 dump_valid SHALL be 0 in IDLE, READ and DONE.
REQ-028 dump_ready asserted while dump_valid=0 SHALL have no effect.

Reset
REQ-029 With nRST=0 at a rising edge, the FSM SHALL go to IDLE and clear idx, dump_data, dump_idx and the checksum accumulator.
REQ-030 During and after reset, busy, done, dump_valid and dump_last SHALL read 0.
REQ-031 Reset mid-dump SHALL abort without a done pulse; the next dump SHALL start from the first index.

Configuration
REQ-032 The macro REGDUMP_CHECKSUM_EN SHALL control the checksum feature.
REQ-033 Without the macro: no CHK state, no accumulator, and dump_last=1 on the idx=31 beat.
REQ-034 With the macro, the accumulator SHALL XOR in each accepted register beat; it clears on the IDLE->READ transition.
REQ-035 With the macro, CHK SHALL present one beat with dump_valid=1, dump_idx=0, dump_data=accumulator and dump_last=1, and hold it until dump_ready.
REQ-036 With the macro, dump_last on the idx=31 beat SHALL be 0.
REQ-037 With the macro, CHK SHALL go to DONE on the handshake.

Verification
REQ-038 Regfile preset r[i]=i*0x11, SKIP_ZERO=0, ready held 1, start pulse -> 32 beats in idx order 0..31 with data i*0x11, one beat every 2 cycles, and done 1 cycle after the last handshake.
REQ-039 SKIP_ZERO=1, same preset -> first beat idx=1, data 0x11; 31 register beats in total.
REQ-040 dump_ready low for 5 cycles on the beat with idx=7 -> dump_valid held 1 and data 0x77 held stable for all 5 cycles; no beat skipped or duplicated.
REQ-041 nRST pulled low while dump_idx=12 -> next cycle busy=0, dump_valid=0, no done pulse; a restart begins at idx 0.
REQ-042 REGDUMP_CHECKSUM_EN defined, r[i]=i -> 33rd beat carries dump_data=0x00000000 (XOR of 0..31) with dump_last=1; the beat with idx=31 carries dump_last=0.
REQ-043 start pulsed while busy, and start held high across DONE -> the pulse while busy is ignored; the held start launches exactly one new dump the cycle after IDLE is re-entered.
